// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown/stopwatch timer.
// Imported by the top, the digit stepper and the handshake interface users.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_MIN  = 4'd0;
  localparam logic       DIR_DOWN = 1'b0;
  localparam logic       DIR_UP   = 1'b1;

  function automatic logic [3:0] clamp_digit(
    input logic [3:0] d
  );
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between the timer and its neighbours.
// master drives the controls, slave is the timer itself.
interface bcd_countdown_timer_if #(
  parameter int NDIG = 2
);

  logic                tick;
  logic                start;
  logic                pause;
  logic                load;
  logic [4*NDIG-1:0]   load_val;
  logic                up_dn;
  logic [4*NDIG-1:0]   value;
  logic                running;
  logic                expired;
  logic                done;

  modport master (
    output tick, start, pause, load,
    output load_val, up_dn,
    input  value, running, expired, done
  );

  modport slave (
    input  tick, start, pause, load,
    input  load_val, up_dn,
    output value, running, expired, done
  );

endinterface

// File: rtl/bcd_digit_step.sv
// One BCD digit incrementer/decrementer with wrap flag.
// wrap feeds the enable of the next more significant digit.
module bcd_digit_step
  import timer_pkg::*;
(
  input  logic [3:0] d_i,
  input  logic       en_i,
  input  logic       up_i,
  output logic [3:0] q_o,
  output logic       wrap_o
);

  always_comb begin
    q_o    = d_i;
    wrap_o = 1'b0;
    if (en_i) begin
      if (up_i == DIR_UP) begin
        wrap_o = (d_i >= BCD_MAX);
        q_o    = wrap_o ? BCD_MIN : d_i + 4'd1;
      end else begin
        wrap_o = (d_i == BCD_MIN);
        q_o    = wrap_o ? BCD_MAX : d_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown/stopwatch with start, pause, load and done pulse.
// Sits between the tick divider and the 7-segment scan driver.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int             NDIG     = 2,
  parameter logic [4*NDIG-1:0] INIT_BCD =
    (4*NDIG)'(8'h30)
) (
  input  logic clk,
  input  logic rst,
  bcd_countdown_timer_if.slave bus
);

  localparam int W = 4 * NDIG;
  localparam logic [W-1:0] ALL9 = {NDIG{BCD_MAX}};
  localparam logic [W-1:0] ALL0 = {NDIG{BCD_MIN}};

  state_e       state_q;
  logic [W-1:0] value_q;
  logic         running_q;
  logic         expired_q;
  logic         done_q;

  logic [W-1:0] step_val;
  logic [W-1:0] step_d;
  logic [W-1:0] clamp_val;
  logic         carry_out;
  logic         up;
  logic         term_cur;
  logic         term_next;

  assign up = (bus.up_dn == DIR_UP);

  for (genvar k = 0; k < NDIG; k++) begin : g_dig
    logic en;
    logic wrap;
    if (k == 0) begin : g_first
      assign en = 1'b1;
    end else begin : g_next
      assign en = g_dig[k-1].wrap;
    end
    bcd_digit_step u_step (
      .d_i    (value_q[4*k +: 4]),
      .en_i   (en),
      .up_i   (bus.up_dn),
      .q_o    (step_val[4*k +: 4]),
      .wrap_o (wrap)
    );
  end

  assign carry_out = g_dig[NDIG-1].wrap;

  // A carry out of the top digit means we sit at terminal: saturate
  assign step_d = carry_out ? value_q : step_val;

  assign term_cur  = up ? (value_q == ALL9)
                        : (value_q == ALL0);
  assign term_next = up ? (step_d == ALL9)
                        : (step_d == ALL0);

  always_comb begin
    clamp_val = '0;
    for (int k = 0; k < NDIG; k++) begin
      clamp_val[4*k +: 4] =
        clamp_digit(bus.load_val[4*k +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      value_q   <= INIT_BCD;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.load) begin
        value_q   <= clamp_val;
        state_q   <= IDLE;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE, PAUSE: begin
            if (bus.start) begin
              if (term_cur) begin
                state_q   <= DONE;
                expired_q <= 1'b1;
                done_q    <= 1'b1;
              end else begin
                state_q   <= RUN;
                running_q <= 1'b1;
              end
            end
          end
          RUN: begin
            if (bus.pause) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end else if (bus.tick) begin
              value_q <= step_d;
              if (term_next) begin
                state_q   <= DONE;
                running_q <= 1'b0;
                expired_q <= 1'b1;
                done_q    <= 1'b1;
              end
            end
          end
          DONE: ;
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            expired_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.value   = value_q;
  assign bus.running = running_q;
  assign bus.expired = expired_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random traffic
// against a decimal-integer reference model.
module tb_bcd_countdown_timer;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;
  localparam int MAXV    = 99;

  logic clk;
  logic rst;

  bcd_countdown_timer_if #(.NDIG(2)) a_if ();
  bcd_countdown_timer_if #(.NDIG(3)) b_if ();

  bcd_countdown_timer #(
    .NDIG     (2),
    .INIT_BCD (8'h30)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  bcd_countdown_timer #(
    .NDIG     (3),
    .INIT_BCD (12'h000)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int m_val;
  int m_st;
  bit m_done;
  bit cur_ud;

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clampdec(input logic [7:0] lv);
    int hi;
    int lo;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  function automatic bit is_term(input int v, input bit ud);
    return ud ? (v == MAXV) : (v == 0);
  endfunction

  task automatic adv(
    input bit ld, input bit ps, input bit st,
    input bit tk, input bit ud,
    input logic [7:0] lv
  );
    a_if.load     = ld;
    a_if.pause    = ps;
    a_if.start    = st;
    a_if.tick     = tk;
    a_if.up_dn    = ud;
    a_if.load_val = lv;
    m_done = 1'b0;
    if (ld) begin
      m_val = clampdec(lv);
      m_st  = S_IDLE;
    end else begin
      case (m_st)
        S_IDLE, S_PAUSE: if (st) begin
          if (is_term(m_val, ud)) begin
            m_st = S_DONE;
            m_done = 1'b1;
          end else m_st = S_RUN;
        end
        S_RUN: if (ps) m_st = S_PAUSE;
        else if (tk) begin
          if (ud) m_val = (m_val < MAXV) ? m_val + 1 : m_val;
          else    m_val = (m_val > 0) ? m_val - 1 : 0;
          if (is_term(m_val, ud)) begin
            m_st = S_DONE;
            m_done = 1'b1;
          end
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    a_if.load  = 1'b0;
    a_if.pause = 1'b0;
    a_if.start = 1'b0;
    a_if.tick  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_if.tick = 0; a_if.start = 0; a_if.pause = 0;
    a_if.load = 0; a_if.load_val = '0; a_if.up_dn = 0;
    b_if.tick = 0; b_if.start = 0; b_if.pause = 0;
    b_if.load = 0; b_if.load_val = '0; b_if.up_dn = 0;
    m_val = 30; m_st = S_IDLE; cur_ud = 1'b0;
    #12;
    n_chk++;
    if (a_if.value !== 8'h30) begin
      n_fail++;
      $display("FAIL rst_value got %h want 30", a_if.value);
    end
    n_chk++;
    if ({a_if.running, a_if.expired, a_if.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags got %b want 000",
               {a_if.running, a_if.expired, a_if.done});
    end
    rst = 1'b0;
  endtask

  task automatic test_countdown();
    int npulse;
    npulse = 0;
    adv(0, 0, 1, 0, 0, 8'h00);
    n_chk++;
    if (a_if.running !== 1'b1 || a_if.value !== 8'h30) begin
      n_fail++;
      $display("FAIL cd_start run %b val %h want 1 30",
               a_if.running, a_if.value);
    end
    for (int i = 1; i <= 30; i++) begin
      adv(0, 0, 0, 1, 0, 8'h00);
      n_chk++;
      if (a_if.value !== bcd2(30 - i) || a_if.done !== m_done) begin
        n_fail++;
        $display("FAIL cd_step%0d val %h done %b want %h %b", i,
                 a_if.value, a_if.done, bcd2(30 - i), m_done);
      end
      if (a_if.done === 1'b1) npulse++;
    end
    n_chk++;
    if (npulse != 1) begin
      n_fail++;
      $display("FAIL cd_pulses got %0d want 1", npulse);
    end
    n_chk++;
    if (a_if.expired !== 1'b1 || a_if.running !== 1'b0) begin
      n_fail++;
      $display("FAIL cd_end exp %b run %b want 1 0",
               a_if.expired, a_if.running);
    end
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 5; i++) begin
      adv(0, 0, 0, 1, 0, 8'h00);
      n_chk++;
      if (a_if.value !== 8'h00 || a_if.done !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_tick%0d val %h done %b want 00 0",
                 i, a_if.value, a_if.done);
      end
    end
    adv(0, 0, 1, 0, 0, 8'h00);
    n_chk++;
    if (a_if.done !== 1'b0 || a_if.expired !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_start done %b exp %b want 0 1",
               a_if.done, a_if.expired);
    end
    adv(1, 0, 0, 0, 0, 8'h05);
    n_chk++;
    if (a_if.value !== 8'h05 || a_if.expired !== 1'b0 ||
        a_if.running !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_load val %h exp %b run %b want 05 0 0",
               a_if.value, a_if.expired, a_if.running);
    end
  endtask

  task automatic test_pause();
    adv(1, 0, 0, 0, 0, 8'h20);
    adv(0, 0, 1, 0, 0, 8'h00);
    adv(0, 1, 0, 1, 0, 8'h00);
    n_chk++;
    if (a_if.value !== 8'h20 || a_if.running !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_enter val %h run %b want 20 0",
               a_if.value, a_if.running);
    end
    for (int i = 0; i < 10; i++) begin
      adv(0, 0, 0, 1, 0, 8'h00);
      n_chk++;
      if (a_if.value !== 8'h20) begin
        n_fail++;
        $display("FAIL pause_hold%0d val %h want 20", i, a_if.value);
      end
    end
    adv(0, 0, 1, 0, 0, 8'h00);
    n_chk++;
    if (a_if.running !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_resume run %b want 1", a_if.running);
    end
    adv(0, 0, 0, 1, 0, 8'h00);
    n_chk++;
    if (a_if.value !== 8'h19) begin
      n_fail++;
      $display("FAIL pause_step val %h want 19", a_if.value);
    end
  endtask

  task automatic test_ripple();
    b_if.load = 1'b1;
    b_if.load_val = 12'h100;
    @(posedge clk); #1;
    b_if.load = 1'b0;
    b_if.start = 1'b1;
    b_if.up_dn = 1'b0;
    @(posedge clk); #1;
    b_if.start = 1'b0;
    b_if.tick = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (b_if.value !== 12'h099) begin
      n_fail++;
      $display("FAIL borrow val %h want 099", b_if.value);
    end
    b_if.up_dn = 1'b1;
    @(posedge clk); #1;
    b_if.tick = 1'b0;
    n_chk++;
    if (b_if.value !== 12'h100 || b_if.running !== 1'b1) begin
      n_fail++;
      $display("FAIL carry val %h run %b want 100 1",
               b_if.value, b_if.running);
    end
  endtask

  task automatic test_up();
    adv(1, 0, 0, 0, 1, 8'h98);
    adv(0, 0, 1, 0, 1, 8'h00);
    adv(0, 0, 0, 1, 1, 8'h00);
    n_chk++;
    if (a_if.value !== 8'h99 || a_if.done !== 1'b1 ||
        a_if.expired !== 1'b1) begin
      n_fail++;
      $display("FAIL up_term val %h done %b exp %b want 99 1 1",
               a_if.value, a_if.done, a_if.expired);
    end
    adv(1, 0, 0, 0, 1, 8'h99);
    adv(0, 0, 1, 0, 1, 8'h00);
    n_chk++;
    if (a_if.value !== 8'h99 || a_if.done !== 1'b1 ||
        a_if.expired !== 1'b1 || a_if.running !== 1'b0) begin
      n_fail++;
      $display("FAIL up_start val %h done %b exp %b run %b want 99 1 1 0",
               a_if.value, a_if.done, a_if.expired, a_if.running);
    end
  endtask

  task automatic test_async_reset();
    adv(1, 0, 0, 0, 0, 8'h45);
    adv(0, 0, 1, 0, 0, 8'h00);
    adv(0, 0, 0, 1, 0, 8'h00);
    adv(0, 0, 0, 1, 0, 8'h00);
    #3;
    rst = 1'b1;
    #1;
    n_chk++;
    if (a_if.value !== 8'h30) begin
      n_fail++;
      $display("FAIL arst_value got %h want 30", a_if.value);
    end
    n_chk++;
    if ({a_if.running, a_if.expired, a_if.done} !== 3'b000) begin
      n_fail++;
      $display("FAIL arst_flags got %b want 000",
               {a_if.running, a_if.expired, a_if.done});
    end
    #10;
    rst = 1'b0;
    m_val = 30;
    m_st = S_IDLE;
    adv(1, 0, 0, 0, 0, 8'hAF);
    n_chk++;
    if (a_if.value !== 8'h99) begin
      n_fail++;
      $display("FAIL clamp got %h want 99", a_if.value);
    end
  endtask

  task automatic test_random();
    bit ld, ps, st, tk;
    logic [7:0] lv;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 19) == 0);
      ps = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 5) == 0);
      tk = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) cur_ud = ~cur_ud;
      lv = 8'($urandom);
      adv(ld, ps, st, tk, cur_ud, lv);
      n_chk++;
      if (a_if.value !== bcd2(m_val)) begin
        n_fail++;
        $display("FAIL rnd%0d_value got %h want %h",
                 i, a_if.value, bcd2(m_val));
      end
      n_chk++;
      if (a_if.running !== (m_st == S_RUN) ||
          a_if.expired !== (m_st == S_DONE)) begin
        n_fail++;
        $display("FAIL rnd%0d_state run %b exp %b want st %0d",
                 i, a_if.running, a_if.expired, m_st);
      end
      n_chk++;
      if (a_if.done !== m_done) begin
        n_fail++;
        $display("FAIL rnd%0d_done got %b want %b",
                 i, a_if.done, m_done);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_countdown();
    test_done_hold();
    test_pause();
    test_ripple();
    test_up();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
